sqsum_seq: RTL and testbench

SQSUM_SEQ -- requirements
Module: sqsum_seq

---
 rtl/sqsum_pkg.sv | 15 +
 rtl/rom.sv | 19 +
 rtl/sqsum_seq.sv | 85 ++++++++
 tb/tb_sqsum_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sqsum_pkg.sv
// Shared definitions for the sum-of-squares sequencer: state encoding and
// default widths for the ROM address, ROM data and the result.
package sqsum_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;
  localparam int SW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rom.sv
// Square lookup ROM: data is addr*addr, purely combinational in addr.
// Sits beside sqsum_seq in the parent, which wires addr and data between them.
module rom #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [DW-1:0] addrWide;

  // Square the presented address; the product is truncated to the data width
  always_comb begin
    addrWide = DW'(addr);
    data     = addrWide * addrWide;
  end

endmodule

// File: rtl/sqsum_seq.sv
// Sum-of-squares sequencer. On start it walks the external square ROM from
// address 0 up to the latched last address n_q, one address per cycle,
// accumulating the returned data. The total is presented on sum with valid
// held until the consumer raises ready. All outputs are registered, so valid
// never follows ready combinationally.
module sqsum_seq
  import sqsum_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] n,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic          busy,
  output logic          valid,
  input  logic          ready,
  output logic [SW-1:0] sum
);

  state_t        state;
  logic [AW-1:0] n_q;
  logic [SW-1:0] acc;
  logic [SW-1:0] dataExt;
  logic [SW-1:0] accNext;

  // Zero-extend the ROM word and form the running total including this address
  always_comb begin
    dataExt = SW'(data);
    accNext = acc + dataExt;
  end

  // Control FSM with registered outputs; reset wins over every other input and
  // discards any partial sum. addr stops at n_q, so it never wraps back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      acc   <= '0;
      n_q   <= '0;
      sum   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= n;
            addr  <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= accNext;
          if (addr != n_q) begin
            addr <= addr + AW'(1);
          end else begin
            sum   <= accNext;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqsum_seq.sv
// Directed bench for sqsum_seq wired to the square ROM. Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_sqsum_seq;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SW = 12;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] n;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          busy;
  logic          valid;
  logic          ready;
  logic [SW-1:0] sum;

  int checks;
  int errors;

  sqsum_seq #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .n     (n),
    .addr  (addr),
    .data  (data),
    .busy  (busy),
    .valid (valid),
    .ready (ready),
    .sum   (sum)
  );

  rom #(.AW(AW), .DW(DW)) romInst (
    .addr (addr),
    .data (data)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs, then advance past the next rising edge
  task automatic applyStimulus(input logic rstV, input logic startV,
                               input logic [AW-1:0] nV, input logic readyV);
    rst   = rstV;
    start = startV;
    n     = nV;
    ready = readyV;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed scenarios with hand-computed sums of squares
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; n = '0; ready = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_sum", sum, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("idle_busy", busy, 0);

    // n=3: addr 0..3, valid 4 cycles after start edge, sum 0+1+4+9=14
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b1);
    checkOutput("n3_busy", busy, 1);
    checkOutput("n3_addr0", addr, 0);
    checkOutput("n3_valid0", valid, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput("n3_addr", addr, i);
      checkOutput("n3_valid_low", valid, 0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n3_valid", valid, 1);
    checkOutput("n3_sum", sum, 14);
    checkOutput("n3_addr_hold", addr, 3);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n3_valid_drop", valid, 0);
    checkOutput("n3_busy_drop", busy, 0);
    checkOutput("n3_sum_hold", sum, 14);

    // n=0: single RUN cycle, sum 0
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b1);
    checkOutput("n0_valid0", valid, 0);
    checkOutput("n0_busy", busy, 1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n0_valid", valid, 1);
    checkOutput("n0_sum", sum, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n0_valid_drop", valid, 0);

    // n=15: 16 RUN cycles, no wrap, sum 1240
    applyStimulus(1'b0, 1'b1, 4'd15, 1'b1);
    checkOutput("n15_addr0", addr, 0);
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput("n15_addr", addr, i);
      checkOutput("n15_valid_low", valid, 0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n15_valid", valid, 1);
    checkOutput("n15_sum", sum, 1240);
    checkOutput("n15_addr_nowrap", addr, 15);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n15_valid_drop", valid, 0);

    // n=5 with ready held low for 3 cycles: sum 55 stable
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkOutput("n5_valid", valid, 1);
    checkOutput("n5_sum", sum, 55);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("n5_valid_hold", valid, 1);
      checkOutput("n5_sum_hold", sum, 55);
      checkOutput("n5_busy_hold", busy, 1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("n5_valid_drop", valid, 0);
    checkOutput("n5_busy_drop", busy, 0);
    checkOutput("n5_sum_keep", sum, 55);

    // start held high, n changed to 9 mid-RUN of an n=4 sum: sum 30
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd9, 1'b1);
      checkOutput("hold_addr", addr, i);
    end
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b1);
    checkOutput("hold_valid", valid, 1);
    checkOutput("hold_sum", sum, 30);
    checkOutput("hold_addr_stop", addr, 4);
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b1);
    checkOutput("hold_idle_busy", busy, 0);
    checkOutput("hold_idle_valid", valid, 0);
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b1);
    checkOutput("hold_restart_busy", busy, 1);
    checkOutput("hold_restart_addr", addr, 0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1);

    // Reset in the third RUN cycle discards the sum; then n=2 gives 5
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd7, 1'b1);
    checkOutput("mid_addr_before", addr, 2);
    applyStimulus(1'b1, 1'b0, 4'd7, 1'b1);
    checkOutput("mid_rst_addr", addr, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_valid", valid, 0);
    checkOutput("mid_rst_sum", sum, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd7, 1'b1);
      checkOutput("mid_no_valid", valid, 0);
    end
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b1);
    checkOutput("n2_valid_low", valid, 0);
    applyStimulus(1'b0, 1'b0, 4'd2, 1'b1);
    checkOutput("n2_valid", valid, 1);
    checkOutput("n2_sum", sum, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
